// File: rtl/buff_use_pkg.sv
// -----------------------------------------------------------------------------
// buff_use_pkg
// Shared types and constants for the buffer-use sequencer.
//   state_e        : sequencer FSM state (IDLE / RUN)
//   SCHED_DEFAULT  : power-up schedule of the classic 26-step / 4-buffer decoder
//   sched_default(): bounded lookup into SCHED_DEFAULT (out-of-range -> 0)
// -----------------------------------------------------------------------------
package buff_use_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_DEPTH   = 26;
  localparam int unsigned DEF_NUM_BUF = 4;

  localparam logic [3:0] SCHED_DEFAULT [0:25] = '{
    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1100,
    4'b0110, 4'b0010, 4'b1001, 4'b1101, 4'b1000, 4'b1110,
    4'b0100, 4'b0110, 4'b0000, 4'b0011, 4'b1011, 4'b0001, 4'b1101,
    4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1001, 4'b1000
  };

  // Out-of-range indices return an empty mask so callers need no guard.
  function automatic logic [3:0] sched_default(input logic [4:0] idx);
    logic [3:0] val;
    if (idx <= 5'd25) begin
      val = SCHED_DEFAULT[idx];
    end else begin
      val = 4'b0000;
    end
    return val;
  endfunction

endpackage

// File: rtl/buff_use_table.sv
// -----------------------------------------------------------------------------
// buff_use_table
// DEPTH x NUM_BUF schedule storage built from flops.
//   clk_i    : clock
//   rst_ni   : async active-low reset, reloads the default schedule
//   we_i     : write strobe (already qualified by the caller)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : asynchronous read address
//   rdata_o  : read data (0 for addresses beyond DEPTH-1)
// -----------------------------------------------------------------------------
module buff_use_table
  import buff_use_pkg::*;
#(
  parameter int unsigned NUM_BUF = 4,
  parameter int unsigned DEPTH   = 26,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [CNT_W-1:0]   waddr_i,
  input  logic [NUM_BUF-1:0] wdata_i,
  input  logic [CNT_W-1:0]   raddr_i,
  output logic [NUM_BUF-1:0] rdata_o
);

  // The built-in schedule only makes sense for the classic geometry.
  localparam bit USE_DEF = (NUM_BUF == DEF_NUM_BUF) && (DEPTH == DEF_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  logic [NUM_BUF-1:0] ent_s [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [NUM_BUF-1:0] RST_VAL =
      USE_DEF ? NUM_BUF'(sched_default(5'(g))) : '0;

    logic [NUM_BUF-1:0] ent_q;

    // One schedule entry: reset to its default, overwritten on an addressed write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ent_q <= RST_VAL;
      end else if (we_i && (waddr_i == CNT_W'(g))) begin
        ent_q <= wdata_i;
      end
    end

    assign ent_s[g] = ent_q;
  end

  // Asynchronous read port with an explicit out-of-range guard.
  always_comb begin
    rdata_o = '0;
    if (raddr_i <= LAST_IDX) begin
      rdata_o = ent_s[raddr_i];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/buff_use_sequencer.sv
// -----------------------------------------------------------------------------
// buff_use_sequencer
// Walks a programmable schedule table and emits a registered buffer-use mask
// per step for the conv datapath buffer bank.
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a run (IDLE only); samples cfg_last / loop_en
//   cfg_last, loop_en   : last step of the run, wrap-around enable
//   adv                 : advance enable (0 = stall)
//   abort               : terminate run at the next edge, no done
//   tbl_we/addr/data    : schedule write port, honoured only in IDLE
//   cnt, buff_use       : current step and its mask (registered)
//   valid, busy, done   : outputs meaningful, run in progress, pass complete
// -----------------------------------------------------------------------------
module buff_use_sequencer
  import buff_use_pkg::*;
#(
  parameter int unsigned NUM_BUF = 4,
  parameter int unsigned DEPTH   = 26,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_last,
  input  logic               loop_en,
  input  logic               adv,
  input  logic               abort,
  input  logic               tbl_we,
  input  logic [CNT_W-1:0]   tbl_addr,
  input  logic [NUM_BUF-1:0] tbl_data,
  output logic [CNT_W-1:0]   cnt,
  output logic [NUM_BUF-1:0] buff_use,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BUF-1:0] buff_q, buff_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               loop_q, loop_d;

  logic               tbl_we_s;
  logic [CNT_W-1:0]   rd_addr_s;
  logic [NUM_BUF-1:0] rd_data_s;
  logic [CNT_W-1:0]   cfg_clamp_s;

  // Writes are only accepted while idle and inside the table.
  assign tbl_we_s    = tbl_we && (state_q == IDLE) && (tbl_addr <= LAST_IDX);
  // Clamping at capture keeps the counter inside the table for any cfg_last.
  assign cfg_clamp_s = (cfg_last > LAST_IDX) ? LAST_IDX : cfg_last;

  // Read address is the step the next advance lands on; step 0 when idle or wrapping.
  always_comb begin
    rd_addr_s = '0;
    if ((state_q == RUN) && (cnt_q != last_q)) begin
      rd_addr_s = cnt_q + CNT_W'(1);
    end else begin
      rd_addr_s = '0;
    end
  end

  buff_use_table #(
    .NUM_BUF (NUM_BUF),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_table (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (tbl_we_s),
    .waddr_i (tbl_addr),
    .wdata_i (tbl_data),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Next-state and next-output logic. The table read happens before any
  // same-edge write commits, so a run started alongside a write to entry 0
  // shows the old entry on step 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buff_d  = buff_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
    loop_d  = loop_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          cnt_d   = '0;
          buff_d  = rd_data_s;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = cfg_clamp_s;
          loop_d  = loop_en;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          buff_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (adv) begin
          if (cnt_q == last_q) begin
            done_d = 1'b1;
            if (loop_q) begin
              cnt_d  = '0;
              buff_d = rd_data_s;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              buff_d  = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            buff_d = rd_data_s;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        buff_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, run configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buff_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buff_q  <= buff_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
    end
  end

  assign cnt      = cnt_q;
  assign buff_use = buff_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_buff_use_sequencer.sv
// -----------------------------------------------------------------------------
// tb_buff_use_sequencer
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model (table array + run bookkeeping in plain integers).
// -----------------------------------------------------------------------------
module tb_buff_use_sequencer;

  localparam int NUM_BUF = 4;
  localparam int DEPTH   = 26;
  localparam int CNT_W   = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   cfg_last;
  logic               loop_en;
  logic               adv;
  logic               abort;
  logic               tbl_we;
  logic [CNT_W-1:0]   tbl_addr;
  logic [NUM_BUF-1:0] tbl_data;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_BUF-1:0] buff_use;
  logic               valid;
  logic               busy;
  logic               done;

  buff_use_sequencer #(
    .NUM_BUF (NUM_BUF),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_last (cfg_last),
    .loop_en  (loop_en),
    .adv      (adv),
    .abort    (abort),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .cnt      (cnt),
    .buff_use (buff_use),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default schedule, written out as integer masks.
  int def_sched [DEPTH] = '{0, 0, 0, 0, 0, 8, 12, 6, 2, 9, 13, 8, 14,
                            4, 6, 0, 3, 11, 1, 13, 8, 12, 2, 3, 9, 8};

  // Reference model state.
  int m_tbl [DEPTH];
  bit m_run;
  int m_cnt;
  int m_last;
  bit m_loop;
  int m_buf;
  bit m_done;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = def_sched[i];
    m_run = 0; m_cnt = 0; m_last = 0; m_loop = 0; m_buf = 0; m_done = 0;
  endtask

  task automatic model_idle();
    m_run = 0; m_cnt = 0; m_buf = 0;
  endtask

  // Apply the rules for one clock edge using the inputs present before it.
  task automatic model_edge();
    int nd;
    nd = 0;
    if (!m_run) begin
      if (start && !abort) begin
        m_run  = 1;
        m_cnt  = 0;
        m_buf  = m_tbl[0];
        m_last = (int'(cfg_last) > DEPTH - 1) ? DEPTH - 1 : int'(cfg_last);
        m_loop = loop_en;
      end
      if (tbl_we && int'(tbl_addr) < DEPTH) m_tbl[tbl_addr] = int'(tbl_data);
    end else if (abort) begin
      model_idle();
    end else if (adv) begin
      if (m_cnt == m_last) begin
        nd = 1;
        if (m_loop) begin
          m_cnt = 0;
          m_buf = m_tbl[0];
        end else begin
          model_idle();
        end
      end else begin
        m_cnt = m_cnt + 1;
        m_buf = m_tbl[m_cnt];
      end
    end
    m_done = (nd != 0);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".cnt"},   int'(cnt),      m_cnt);
    check_eq({tag, ".buf"},   int'(buff_use), m_buf);
    check_eq({tag, ".valid"}, int'(valid),    int'(m_run));
    check_eq({tag, ".busy"},  int'(busy),     int'(m_run));
    check_eq({tag, ".done"},  int'(done),     int'(m_done));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input bit s, input int cl, input bit le, input bit a,
                        input bit ab, input bit we, input int wa, input int wd);
    start    = s;
    cfg_last = CNT_W'(cl);
    loop_en  = le;
    adv      = a;
    abort    = ab;
    tbl_we   = we;
    tbl_addr = CNT_W'(wa);
    tbl_data = NUM_BUF'(wd);
  endtask

  // Start a run and clear the start pulse.
  task automatic start_run(input int cl, input bit le, input string tag);
    set_in(1, cl, le, 0, 0, 0, 0, 0);
    tick(tag);
    set_in(0, cl, le, 1, 0, 0, 0, 0);
  endtask

  // Advance until the run returns to idle, bounded.
  task automatic run_to_idle(input string tag);
    int n;
    n = 0;
    adv = 1'b1;
    while (m_run && n < 40) begin
      tick(tag);
      n++;
    end
    check_eq({tag, ".ended"}, int'(m_run), 0);
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full default schedule, then idle.
    start_run(25, 0, "full_start");
    check_eq("full_step0_buf", int'(buff_use), def_sched[0]);
    run_to_idle("full_run");

    // Stall for three cycles at step 6.
    start_run(25, 0, "stall_start");
    while (m_cnt != 6) tick("stall_adv");
    adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold");
      check_eq("stall_cnt", int'(cnt), 6);
      check_eq("stall_buf", int'(buff_use), 12);
    end
    adv = 1'b1;
    tick("stall_resume");
    check_eq("resume_cnt", int'(cnt), 7);
    check_eq("resume_buf", int'(buff_use), 6);
    run_to_idle("stall_run");

    // Rotating mask in loop mode.
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, i, 1 << i);
      tick("loop_wr");
    end
    start_run(3, 1, "loop_start");
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick("loop_adv");
      check_eq("loop_buf", int'(buff_use), 1 << ((i + 1) % 4));
      if (done) seen_done++;
    end
    check_eq("loop_dones", seen_done, 3);
    abort = 1'b1;
    tick("loop_abort");
    abort = 1'b0;

    // Abort at step 10, then restart from 0.
    start_run(25, 0, "abort_start");
    while (m_cnt != 10) tick("abort_adv");
    abort = 1'b1;
    tick("abort_edge");
    check_eq("abort_valid", int'(valid), 0);
    check_eq("abort_done", int'(done), 0);
    abort = 1'b0;
    start_run(25, 0, "restart");
    check_eq("restart_cnt", int'(cnt), 0);
    run_to_idle("restart_run");

    // Clamp of cfg_last plus ignored writes during the run.
    start_run(31, 0, "clamp_start");
    tbl_we = 1'b1; tbl_addr = 5'd9; tbl_data = 4'hF;
    while (m_cnt != 25 && m_run) tick("clamp_adv");
    check_eq("clamp_cnt", int'(cnt), 25);
    tbl_we = 1'b0;
    tick("clamp_last");
    check_eq("clamp_done", int'(done), 1);
    start_run(25, 0, "tbl_kept");
    run_to_idle("tbl_kept_run");

    // Same-edge start and write to entry 0 with loop: old value first, new on wrap.
    set_in(1, 1, 1, 0, 0, 1, 0, 5);
    tick("same_edge");
    check_eq("same_edge_buf", int'(buff_use), 1);
    set_in(0, 1, 1, 1, 0, 0, 0, 0);
    tick("same_edge_s1");
    tick("same_edge_wrap");
    check_eq("same_edge_new", int'(buff_use), 5);
    abort = 1'b1;
    tick("same_edge_abort");
    abort = 1'b0;

    // Single-step run.
    start_run(0, 0, "single_start");
    tick("single_adv");
    check_eq("single_done", int'(done), 1);

    // Asynchronous reset mid-run at step 12.
    start_run(25, 0, "arst_start");
    while (m_cnt != 12) tick("arst_adv");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("arst_async");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    start_run(25, 0, "arst_default");
    run_to_idle("arst_default_run");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 11) == 0, $urandom_range(0, 31), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 31), $urandom_range(0, 15));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
